dmem_uart_bridge: RTL

//  Sits on the CPU_Core data-memory bus, between the core and the data RAM.

---
 rtl/dmem_uart_pkg.sv | 29 ++
 rtl/dmem_uart_bridge_sync_fifo.sv | 57 +++++
 rtl/dmem_uart_bridge.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_uart_pkg.sv
// Shared definitions for the data-memory UART bridge: MMIO map, STATUS layout, TX FSM states.
package dmem_uart_pkg;

   // Upper 16 bytes of the 10-bit data address space belong to the UART
   localparam logic [9:0] MMIO_BASE  = 10'h3F0;
   localparam int         TXDATA_OFS = 'h0;
   localparam int         STATUS_OFS = 'h4;

   // Word indices inside the MMIO window (address bits [3:2])
   localparam logic [1:0] TXDATA_WORD = 2'(TXDATA_OFS >> 2);
   localparam logic [1:0] STATUS_WORD = 2'(STATUS_OFS >> 2);

   // STATUS register bit positions
   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_CNT_MSB = 7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/dmem_uart_bridge_sync_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       CLK,
   input  logic                       RSTn,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign full     = (r_count == CNT_W'(DEPTH));
   assign empty    = (r_count == '0);
   assign count    = r_count;
   assign dout     = r_mem[r_rdPtr];
   assign w_doPush = push & ~full;
   assign w_doPop  = pop & ~empty;

   // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset because the pointers define validity
   always_ff @(posedge CLK) begin
      if (w_doPush) r_mem[r_wrPtr] <= din;
   end

endmodule

// File: rtl/dmem_uart_bridge.sv
// Data-memory bus bridge: passes RAM traffic through and maps a UART TX at 0x3F0-0x3FF.
// Optional even-parity bit is enabled by defining DMEM_UART_PARITY_EN.
module dmem_uart_bridge
   import dmem_uart_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [ADDR_W-1:0] address_DMEM,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              ram_MemWrite,
   output logic              ram_MemRead,
   input  logic [DATA_W-1:0] ram_read_data,
   output logic              uart_tx
);

   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   logic              w_mmioSel;
   logic [1:0]        w_regIdx;
   logic              w_txPush;
   logic              w_statusWr;
   logic              w_fifoFull;
   logic              w_fifoEmpty;
   logic [CNT_W-1:0]  w_fifoCount;
   logic [7:0]        w_fifoDout;
   logic              w_fifoPop;
   logic              w_baudEnd;
   logic              w_busy;
   logic [DATA_W-1:0] w_mmioData;
   logic              w_unused;

   uart_state_t       r_state;
   logic [BAUD_W-1:0] r_baudCnt;
   logic [2:0]        r_bitCnt;
   logic [7:0]        r_shift;
   logic              r_tx;
   logic              r_overflow;

   assign w_mmioSel    = (address_DMEM[9:4] == MMIO_BASE[9:4]);
   assign w_regIdx     = address_DMEM[3:2];
   assign ram_MemWrite = MemWrite & ~w_mmioSel;
   assign ram_MemRead  = MemRead & ~w_mmioSel;
   assign w_txPush     = MemWrite & w_mmioSel & (w_regIdx == TXDATA_WORD);
   assign w_statusWr   = MemWrite & w_mmioSel & (w_regIdx == STATUS_WORD);
   assign w_baudEnd    = (r_baudCnt == BAUD_LAST);
   assign w_busy       = (r_state != IDLE);
   assign w_fifoPop    = ~w_fifoEmpty & ((r_state == IDLE) | ((r_state == STOP) & w_baudEnd));
   assign uart_tx      = r_tx;
   assign w_unused     = ^{address_DMEM[1:0], write_data[DATA_W-1:8], MemRead};

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_txFifo (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .push  (w_txPush),
      .pop   (w_fifoPop),
      .din   (write_data[7:0]),
      .dout  (w_fifoDout),
      .full  (w_fifoFull),
      .empty (w_fifoEmpty),
      .count (w_fifoCount)
   );

   // MMIO register read mux; only STATUS returns non-zero data
   always_comb begin
      w_mmioData = '0;
      if (w_regIdx == STATUS_WORD) begin
         w_mmioData[ST_FULL]                = w_fifoFull;
         w_mmioData[ST_EMPTY]               = w_fifoEmpty;
         w_mmioData[ST_BUSY]                = w_busy;
         w_mmioData[ST_OVF]                 = r_overflow;
         w_mmioData[ST_CNT_MSB:ST_CNT_LSB]  = 4'(w_fifoCount);
      end
   end

   assign read_data = w_mmioSel ? w_mmioData : ram_read_data;

   // Sticky overflow flag: set by a dropped push, cleared by any STATUS write
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_overflow <= 1'b0;
      end else if (w_txPush && w_fifoFull) begin
         r_overflow <= 1'b1;
      end else if (w_statusWr) begin
         r_overflow <= 1'b0;
      end
   end

   // Transmit FSM: each start/data/parity/stop slot lasts CLKS_PER_BIT cycles
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_state   <= IDLE;
         r_baudCnt <= '0;
         r_bitCnt  <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_baudCnt <= '0;
               r_bitCnt  <= '0;
               r_tx      <= 1'b1;
               if (!w_fifoEmpty) begin
                  r_shift <= w_fifoDout;
                  r_state <= START;
                  r_tx    <= 1'b0;
               end
            end
            START: begin
               if (w_baudEnd) begin
                  r_baudCnt <= '0;
                  r_bitCnt  <= '0;
                  r_state   <= DATA;
                  r_tx      <= r_shift[0];
               end else begin
                  r_baudCnt <= r_baudCnt + 1'b1;
               end
            end
            DATA: begin
               if (w_baudEnd) begin
                  r_baudCnt <= '0;
                  if (r_bitCnt == 3'd7) begin
                     r_bitCnt <= '0;
`ifdef DMEM_UART_PARITY_EN
                     r_state  <= PARITY;
                     r_tx     <= ^r_shift;
`else
                     r_state  <= STOP;
                     r_tx     <= 1'b1;
`endif
                  end else begin
                     r_bitCnt <= r_bitCnt + 3'd1;
                     r_tx     <= r_shift[r_bitCnt + 3'd1];
                  end
               end else begin
                  r_baudCnt <= r_baudCnt + 1'b1;
               end
            end
`ifdef DMEM_UART_PARITY_EN
            PARITY: begin
               if (w_baudEnd) begin
                  r_baudCnt <= '0;
                  r_state   <= STOP;
                  r_tx      <= 1'b1;
               end else begin
                  r_baudCnt <= r_baudCnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (w_baudEnd) begin
                  r_baudCnt <= '0;
                  if (!w_fifoEmpty) begin
                     r_shift <= w_fifoDout;
                     r_state <= START;
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                     r_tx    <= 1'b1;
                  end
               end else begin
                  r_baudCnt <= r_baudCnt + 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_baudCnt <= '0;
               r_bitCnt  <= '0;
               r_tx      <= 1'b1;
            end
         endcase
      end
   end

endmodule
